// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with shadow registers and registered pin outputs.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 17
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [15:0] DataIn,
  input  logic [3:0]  DpIn,
  input  logic        Load,
  input  logic        Blank,
  output logic [3:0]  AN,
  output logic [6:0]  Seg,
  output logic        DP
);

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [1:0]       index_q, index_d;
  logic [15:0]      dispReg_q, dispReg_d;
  logic [3:0]       dpReg_q, dpReg_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic [3:0] nibble;
  logic       digitOff;

  function automatic logic [6:0] hexToSeg(input logic [3:0] value);
    logic [6:0] segs;
    case (value)
      4'h0:    segs = 7'b1000000;
      4'h1:    segs = 7'b1111001;
      4'h2:    segs = 7'b0100100;
      4'h3:    segs = 7'b0110000;
      4'h4:    segs = 7'b0011001;
      4'h5:    segs = 7'b0010010;
      4'h6:    segs = 7'b0000010;
      4'h7:    segs = 7'b1111000;
      4'h8:    segs = 7'b0000000;
      4'h9:    segs = 7'b0010000;
      4'hA:    segs = 7'b0001000;
      4'hB:    segs = 7'b0000011;
      4'hC:    segs = 7'b1000110;
      4'hD:    segs = 7'b0100001;
      4'hE:    segs = 7'b0000110;
      default: segs = 7'b0001110;
    endcase
    return segs;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] nonZeroAbove;
  logic [3:0] digitShown;

  // A digit stays lit if it or any more significant nibble is non-zero, or its point is set.
  always_comb begin
    nonZeroAbove    = 4'b0000;
    nonZeroAbove[3] = |dispReg_q[15:12];
    nonZeroAbove[2] = nonZeroAbove[3] | (|dispReg_q[11:8]);
    nonZeroAbove[1] = nonZeroAbove[2] | (|dispReg_q[7:4]);
    nonZeroAbove[0] = 1'b1;
    digitShown      = nonZeroAbove | dpReg_q;
    digitOff        = Blank | ~digitShown[index_q];
  end
`else
  always_comb begin
    digitOff = Blank;
  end
`endif

  always_comb begin
    tick      = (presc_q == PrescMax);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    index_d   = tick ? index_q + 2'd1 : index_q;
    dispReg_d = Load ? DataIn : dispReg_q;
    dpReg_d   = Load ? DpIn : dpReg_q;
    nibble    = dispReg_q[{index_q, 2'b00} +: 4];
    an_d      = digitOff ? 4'b1111 : ~(4'b0001 << index_q);
    seg_d     = digitOff ? 7'b1111111 : hexToSeg(nibble);
    dp_d      = digitOff ? 1'b1 : ~dpReg_q[index_q];
  end

  // Outputs are built from the pre-edge index and shadow data, so a Load or tick shows one cycle later.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc_q   <= '0;
      index_q   <= 2'd0;
      dispReg_q <= 16'h0000;
      dpReg_q   <= 4'h0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      index_q   <= index_d;
      dispReg_q <= dispReg_d;
      dpReg_q   <= dpReg_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign AN  = an_q;
  assign Seg = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: the driver queues the expected pin state per edge, a monitor pops and compares.
module tb_seg_scan_driver;

  localparam int ClkDiv = 4;

  logic        CLK;
  logic        RST_n;
  logic [15:0] DataIn;
  logic [3:0]  DpIn;
  logic        Load;
  logic        Blank;
  logic [3:0]  AN;
  logic [6:0]  Seg;
  logic        DP;

  int checks = 0;
  int errors = 0;

  logic [11:0] expQ[$];

  int          mPresc;
  int          mIdx;
  logic [15:0] mDisp;
  logic [3:0]  mDp;

  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_driver #(.CLK_DIV(ClkDiv), .CNT_W(3)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .DataIn(DataIn),
    .DpIn  (DpIn),
    .Load  (Load),
    .Blank (Blank),
    .AN    (AN),
    .Seg   (Seg),
    .DP    (DP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected {AN, Seg, DP} for a given pre-edge scan state.
  function automatic logic [11:0] modelOut(input int idx, input logic [15:0] disp,
                                           input logic [3:0] dp, input logic blank);
    logic [3:0] anv;
    logic [3:0] nib;
    logic       off;
    case (idx)
      0:       anv = 4'b1110;
      1:       anv = 4'b1101;
      2:       anv = 4'b1011;
      default: anv = 4'b0111;
    endcase
    nib = 4'((disp >> (4 * idx)) & 16'h000F);
    off = blank;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 0 && (disp >> (4 * idx)) == 16'h0000 && !dp[idx]) off = 1'b1;
`endif
    if (off) return {4'b1111, 7'b1111111, 1'b1};
    return {anv, segTable[nib], ~dp[idx]};
  endfunction

  task automatic modelReset();
    mPresc = 0;
    mIdx   = 0;
    mDisp  = 16'h0000;
    mDp    = 4'h0;
  endtask

  task automatic stepCycle();
    logic [11:0] e;
    e = modelOut(mIdx, mDisp, mDp, Blank);
    if (mPresc == ClkDiv - 1) begin
      mPresc = 0;
      mIdx   = (mIdx + 1) % 4;
    end else begin
      mPresc++;
    end
    if (Load) begin
      mDisp = DataIn;
      mDp   = DpIn;
    end
    @(posedge CLK);
    #1;
    expQ.push_back(e);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp);
    DataIn = data;
    DpIn   = dp;
    Load   = 1'b1;
    stepCycle();
    Load   = 1'b0;
  endtask

  task automatic runUntilIdx(input int idx);
    for (int i = 0; i < 16 && mIdx != idx; i++) stepCycle();
    checkOutput("reachSlot", mIdx, idx);
  endtask

  // Monitor: every falling edge compares the pins against the oldest queued expectation.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("AN",  AN,  e[11:8]);
        checkOutput("Seg", Seg, e[7:1]);
        checkOutput("DP",  DP,  e[0]);
      end
    end
  end

  initial begin
    RST_n  = 1'b1;
    DataIn = 16'h0000;
    DpIn   = 4'h0;
    Load   = 1'b0;
    Blank  = 1'b0;
    modelReset();

    #2 RST_n = 1'b0;
    #1;
    checkOutput("resetAN",  AN,  4'b1111);
    checkOutput("resetSeg", Seg, 7'b1111111);
    checkOutput("resetDP",  DP,  1'b1);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("holdResetAN", AN, 4'b1111);
    RST_n = 1'b1;
    modelReset();

    runCycles(1);
    runCycles(8);

    applyStimulus(16'h1234, 4'h0);
    runCycles(20);

    applyStimulus(16'hABCD, 4'b0100);
    runCycles(20);

    runUntilIdx(2);
    Blank = 1'b1;
    runCycles(6);
    Blank = 1'b0;
    runCycles(8);

    runUntilIdx(1);
    applyStimulus(16'hFFFF, 4'h0);
    runCycles(8);

    for (int i = 0; i < 8 && mPresc != ClkDiv - 1; i++) stepCycle();
    applyStimulus(16'h5678, 4'b0001);
    runCycles(8);

    runUntilIdx(2);
    runCycles(1);
    #5;
    RST_n = 1'b0;
    #1;
    checkOutput("midScanResetAN",  AN,  4'b1111);
    checkOutput("midScanResetSeg", Seg, 7'b1111111);
    checkOutput("midScanResetDP",  DP,  1'b1);
    #1;
    RST_n = 1'b1;
    modelReset();
    runCycles(1);
    runCycles(16);

    applyStimulus(16'h0042, 4'h0);
    runCycles(16);
    applyStimulus(16'h0000, 4'h0);
    runCycles(16);
    applyStimulus(16'h0042, 4'b1000);
    runCycles(16);

    @(negedge CLK);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
